wgt_feeder: RTL and testbench
=============================

Name: wgt_feeder

Overview:
- Weight-side master for the PE array.
- Fetches per-kernel weight groups from the weight SRAM and serialises them onto a shared signed 8-bit weight bus.
- Drives a one-hot per-PE write-strobe vector (`wgt_read`) so each PE weight register captures its own tap.
- Holds each loaded kernel until the array releases it, then loads the next, for `num_kern` kernels per job.

Parameters:
- NPE, 9, number of PE weight registers fed per kernel (KSIZE*KSIZE taps, tap i -> PE i).
- ADDR_W, 10, weight SRAM address width.
- KCNT_W, 8, width of the kernel-count field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle job request; sampled only in IDLE.
- base_addr  in  ADDR_W  SRAM address of tap 0 of kernel 0; captured on accepted start.
- num_kern  in  KCNT_W  kernels in job; captured on accepted start.
- kern_release  in  1  PE array finished with current kernel; sampled only in HOLD.
- mem_en  out  1  SRAM read enable (registered).
- mem_addr  out  ADDR_W  SRAM read address (registered).
- mem_rdata  in  8  signed SRAM read data; valid exactly 1 cycle after mem_en.
- wgt_out  out  8  signed weight bus to all PEs (registered).
- wgt_read  out  NPE  one-hot PE capture strobe (registered); bit i pairs with tap i.
- kern_loaded  out  1  one-cycle pulse: all NPE taps of current kernel delivered.
- busy  out  1  high from the first FETCH cycle until the job ends.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. rst wins over every other input in the same cycle. Mid-job reset aborts the job with no done pulse; outputs are 0 from the next cycle.
- States: IDLE, FETCH, DRAIN, HOLD, FIN.
- IDLE -> FETCH on start when num_kern != 0. IDLE -> FIN on start when num_kern == 0.
- FETCH lasts exactly NPE cycles.
  - mem_en = 1 in each FETCH cycle.
  - mem_addr = base_addr + kidx*NPE + tidx, modulo 2^ADDR_W (wraps, no error).
  - tidx runs 0..NPE-1.
- DRAIN lasts 2 cycles; it flushes the SRAM latency and the output register. It then enters HOLD.
- Data path:
  - Cycle after mem_en: the tap register takes mem_rdata.
  - Following cycle: wgt_out = that tap and wgt_read = (1 << tidx_delayed).
  - Tap issued with mem_en at cycle T is therefore presented at T+2.
  - wgt_read = 0 and wgt_out holds its last value whenever no tap is presented.
  - Data passes through unmodified (signed 8-bit, no rounding or sign change).
- kern_loaded = 1 in the first HOLD cycle only, which is the cycle after tap NPE-1 is presented.
- HOLD waits for kern_release; kern_release is honoured in any HOLD cycle, including the kern_loaded cycle. On release:
  - kidx+1 < num_kern: kidx++, tidx = 0, go to FETCH.
  - Otherwise go to FIN.
- FIN lasts 1 cycle: done = 1, busy = 0, then IDLE.
- busy = 1 in FETCH, DRAIN and HOLD; 0 in IDLE and FIN.
- Ignored inputs:
  - start while not in IDLE (no re-capture).
  - kern_release outside HOLD, with no memory of it (the array must re-assert it in HOLD).
- base_addr and num_kern changes after capture have no effect on the running job.
- Throughput: one tap per cycle; kernel-to-kernel gap = NPE + 3 cycles + release wait.

Test Plan:
- Single kernel: NPE=9, base_addr=0x010, num_kern=1, SRAM[0x010+i] = i-4, start at cycle 0. Expect:
  - mem_en in cycles 1-9 with addrs 0x010..0x018.
  - wgt_read = 1<<i with wgt_out = i-4 in cycle 3+i (-4..4).
  - kern_loaded at cycle 12; kern_release at cycle 12 gives done at 13.
  - busy high in cycles 1-12.
- Multi-kernel with held release: num_kern=3, kern_release raised 5 cycles after each kern_loaded. Expect:
  - Kernel 1 fetches 0x019..0x021, kernel 2 fetches 0x022..0x02A.
  - Each FETCH starts the cycle after release.
  - Exactly 27 wgt_read pulses, 3 kern_loaded pulses, 1 done.
- Address wrap: base_addr=0x3FC, num_kern=1. Expect mem_addr sequence 0x3FC,0x3FD,0x3FE,0x3FF,0x000..0x004.
- Zero and ignored inputs:
  - num_kern=0: done at cycle 1, no mem_en, no wgt_read, busy stays 0.
  - start pulsed during FETCH: no effect.
  - kern_release pulsed during FETCH/DRAIN: no effect, HOLD still waits.
- Signed extremes: SRAM taps 0x80 and 0x7F. Expect wgt_out = -128 and +127, bit-exact.
- Reset mid-job: rst at cycle 6 of the first FETCH. Expect:
  - From cycle 7: mem_en=0, wgt_read=0, busy=0, no done pulse.
  - A new start after rst deasserts replays from tap 0 at base_addr.

Source files
------------

// File: rtl/wgt_feeder.sv
// wgt_feeder: weight-side master for the PE array.
// For every kernel of a job it reads NPE taps from the weight SRAM. It
// places each tap on the shared weight bus with a one-hot capture strobe,
// so that PE i latches tap i. The loaded kernel is then held until the
// array releases it.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle job request (accepted in IDLE only)
//   base_addr       SRAM address of tap 0 of kernel 0 (captured on start)
//   num_kern        kernels in the job (captured on start)
//   kern_release    array is done with the current kernel (HOLD only)
//   mem_en/mem_addr registered SRAM read request
//   mem_rdata       SRAM read data, valid one cycle after mem_en
//   wgt_out         registered signed weight bus
//   wgt_read        registered one-hot PE capture strobe
//   kern_loaded     pulse in the first HOLD cycle
//   busy            high in FETCH/DRAIN/HOLD
//   done            pulse in FIN
module wgt_feeder #(
    parameter int NPE    = 9,
    parameter int ADDR_W = 10,
    parameter int KCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [KCNT_W-1:0] num_kern,
    input  logic              kern_release,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        wgt_out,
    output logic [NPE-1:0]    wgt_read,
    output logic              kern_loaded,
    output logic              busy,
    output logic              done
);

    localparam int TIDX_W = (NPE > 1) ? $clog2(NPE) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_HOLD  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [TIDX_W-1:0]   tidx_q, tidx_d;
    logic [KCNT_W-1:0]   kidx_q, kidx_d;
    logic [KCNT_W-1:0]   nkern_q, nkern_d;
    logic [ADDR_W-1:0]   kbase_q, kbase_d;   // base + kidx*NPE, kept as a running sum
    logic                dcnt_q, dcnt_d;
    logic                mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                rd_vld_q, rd_vld_d;  // mem_rdata carries a tap this cycle
    logic [TIDX_W-1:0]   rd_tidx_q, rd_tidx_d;
    logic [7:0]          wgt_out_q, wgt_out_d;
    logic [NPE-1:0]      wgt_read_q, wgt_read_d;
    logic                kern_loaded_q, kern_loaded_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Control FSM: next state, counters, and the registered outputs that
    // belong to the state being entered.
    always_comb begin
        state_d       = state_q;
        tidx_d        = tidx_q;
        kidx_d        = kidx_q;
        nkern_d       = nkern_q;
        kbase_d       = kbase_q;
        dcnt_d        = dcnt_q;
        mem_en_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        kern_loaded_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nkern_d = num_kern;
                    kbase_d = base_addr;
                    kidx_d  = {KCNT_W{1'b0}};
                    tidx_d  = {TIDX_W{1'b0}};
                    if (num_kern != {KCNT_W{1'b0}}) begin
                        state_d    = S_FETCH;
                        mem_en_d   = 1'b1;
                        mem_addr_d = base_addr;
                        busy_d     = 1'b1;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                busy_d = 1'b1;
                if (tidx_q == TIDX_W'(NPE - 1)) begin
                    state_d = S_DRAIN;
                    dcnt_d  = 1'b0;
                end else begin
                    tidx_d     = tidx_q + TIDX_W'(1);
                    mem_en_d   = 1'b1;
                    mem_addr_d = kbase_q + ADDR_W'(tidx_q) + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                busy_d = 1'b1;
                if (dcnt_q) begin
                    state_d       = S_HOLD;
                    kern_loaded_d = 1'b1;
                end else begin
                    dcnt_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (kern_release) begin
                    // Widen by one bit so kidx+1 cannot wrap before the compare.
                    if (({1'b0, kidx_q} + {{KCNT_W{1'b0}}, 1'b1}) < {1'b0, nkern_q}) begin
                        state_d    = S_FETCH;
                        kidx_d     = kidx_q + KCNT_W'(1);
                        tidx_d     = {TIDX_W{1'b0}};
                        kbase_d    = kbase_q + ADDR_W'(NPE);
                        mem_en_d   = 1'b1;
                        mem_addr_d = kbase_q + ADDR_W'(NPE);
                        busy_d     = 1'b1;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Data path: the SRAM answers one cycle after mem_en, and the tap is
    // registered onto the bus together with its strobe one cycle later.
    always_comb begin
        rd_vld_d  = mem_en_q;
        rd_tidx_d = tidx_q;
        if (rd_vld_q) begin
            wgt_out_d  = mem_rdata;
            wgt_read_d = {{(NPE-1){1'b0}}, 1'b1} << rd_tidx_q;
        end else begin
            wgt_out_d  = wgt_out_q;
            wgt_read_d = {NPE{1'b0}};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tidx_q        <= {TIDX_W{1'b0}};
            kidx_q        <= {KCNT_W{1'b0}};
            nkern_q       <= {KCNT_W{1'b0}};
            kbase_q       <= {ADDR_W{1'b0}};
            dcnt_q        <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= {ADDR_W{1'b0}};
            rd_vld_q      <= 1'b0;
            rd_tidx_q     <= {TIDX_W{1'b0}};
            wgt_out_q     <= 8'h00;
            wgt_read_q    <= {NPE{1'b0}};
            kern_loaded_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tidx_q        <= tidx_d;
            kidx_q        <= kidx_d;
            nkern_q       <= nkern_d;
            kbase_q       <= kbase_d;
            dcnt_q        <= dcnt_d;
            mem_en_q      <= mem_en_d;
            mem_addr_q    <= mem_addr_d;
            rd_vld_q      <= rd_vld_d;
            rd_tidx_q     <= rd_tidx_d;
            wgt_out_q     <= wgt_out_d;
            wgt_read_q    <= wgt_read_d;
            kern_loaded_q <= kern_loaded_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_addr    = mem_addr_q;
    assign wgt_out     = wgt_out_q;
    assign wgt_read    = wgt_read_q;
    assign kern_loaded = kern_loaded_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_wgt_feeder.sv
// Testbench for wgt_feeder. The drivers push expected events (cycle and
// value) into queues, and a negedge monitor pops and compares them
// whenever the DUT raises mem_en, wgt_read, kern_loaded or done.
module tb_wgt_feeder;

    localparam int NPE    = 9;
    localparam int ADDR_W = 10;
    localparam int KCNT_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [KCNT_W-1:0] num_kern = '0;
    logic              kern_release = 1'b0;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;
    logic [7:0]        wgt_out;
    logic [NPE-1:0]    wgt_read;
    logic              kern_loaded;
    logic              busy;
    logic              done;

    wgt_feeder #(.NPE(NPE), .ADDR_W(ADDR_W), .KCNT_W(KCNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_kern(num_kern), .kern_release(kern_release), .mem_en(mem_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .wgt_out(wgt_out),
        .wgt_read(wgt_read), .kern_loaded(kern_loaded), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM model with one cycle read latency.
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct { int c; int a; int b; } ev_t;
    ev_t q_addr[$];
    ev_t q_wgt[$];
    ev_t q_kl[$];
    ev_t q_done[$];
    int busy_lo = 0;
    int busy_hi = 0;
    int n_checks = 0;
    int n_err = 0;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, cyc, act, act, exp, exp);
        end
    endtask

    task automatic unexpected(string name, int val);
        n_checks++;
        n_err++;
        $display("FAIL %s @cyc %0d: unexpected event, value 0x%0h", name, cyc, val);
    endtask

    // Monitor: compare each DUT event against the head of its queue.
    always @(negedge clk) begin
        ev_t e;
        if (mem_en) begin
            if (q_addr.size() == 0) unexpected("mem_en", int'(mem_addr));
            else begin
                e = q_addr.pop_front();
                chk("mem_en_cycle", cyc, e.c);
                chk("mem_addr", int'(mem_addr), e.a);
            end
        end
        if (wgt_read != '0) begin
            if (q_wgt.size() == 0) unexpected("wgt_read", int'(wgt_read));
            else begin
                e = q_wgt.pop_front();
                chk("wgt_cycle", cyc, e.c);
                chk("wgt_read", int'(wgt_read), e.a);
                chk("wgt_out", int'($signed(wgt_out)), e.b);
            end
        end
        if (kern_loaded) begin
            if (q_kl.size() == 0) unexpected("kern_loaded", 1);
            else begin
                e = q_kl.pop_front();
                chk("kern_loaded_cycle", cyc, e.c);
            end
        end
        if (done) begin
            if (q_done.size() == 0) unexpected("done", 1);
            else begin
                e = q_done.pop_front();
                chk("done_cycle", cyc, e.c);
            end
        end
        if (!rst) chk("busy", int'(busy), int'(cyc >= busy_lo && cyc < busy_hi));
    end

    task automatic goto(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_drained(string name);
        chk(name, q_addr.size() + q_wgt.size() + q_kl.size() + q_done.size(), 0);
    endtask

    // Issue one job and push its expected events; rel_d = release delay
    // after each kern_loaded; poke adds stray start/release pulses.
    task automatic run_job(int base, int nk, int rel_d, bit poke);
        int c0, f, l, r, last_data, a;
        int rel[$];
        ev_t e;
        @(posedge clk);
        #1;
        c0 = cyc;
        base_addr = ADDR_W'(base);
        num_kern  = KCNT_W'(nk);
        start     = 1'b1;
        last_data = int'($signed(wgt_out));
        if (nk == 0) begin
            e = '{c0 + 1, 0, 0}; q_done.push_back(e);
            busy_lo = 0; busy_hi = 0;
        end else begin
            f = c0 + 1;
            for (int k = 0; k < nk; k++) begin
                for (int i = 0; i < NPE; i++) begin
                    a = (base + k * NPE + i) % (1 << ADDR_W);
                    e = '{f + i, a, 0}; q_addr.push_back(e);
                    e = '{f + 2 + i, 1 << i, int'($signed(mem[a]))}; q_wgt.push_back(e);
                    last_data = int'($signed(mem[a]));
                end
                l = f + 11;
                e = '{l, 0, 0}; q_kl.push_back(e);
                r = l + rel_d;
                rel.push_back(r);
                f = r + 1;
            end
            e = '{r + 1, 0, 0}; q_done.push_back(e);
            busy_lo = c0 + 1; busy_hi = r + 1;
        end
        goto(c0 + 1);
        start = 1'b0;
        base_addr = ADDR_W'(10'h2AA);
        num_kern  = KCNT_W'(8'd7);
        if (poke && nk > 0) begin
            goto(c0 + 4); start = 1'b1; base_addr = ADDR_W'(10'h200);
            goto(c0 + 5); start = 1'b0; kern_release = 1'b1;
            goto(c0 + 6); kern_release = 1'b0;
            goto(c0 + 10); kern_release = 1'b1;
            goto(c0 + 11); kern_release = 1'b0;
        end
        foreach (rel[j]) begin
            goto(rel[j]); kern_release = 1'b1;
            goto(rel[j] + 1); kern_release = 1'b0;
        end
        goto(c0 + 1 + (nk == 0 ? 0 : rel[rel.size()-1] - c0) + 3);
        check_drained("queues_drained");
        chk("wgt_hold", int'($signed(wgt_out)), last_data);
    endtask

    initial begin
        int c0;
        ev_t e;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i * 37 + 5);
        for (int i = 0; i < NPE; i++) mem[10'h010 + i] = 8'(i - 4);
        mem[10'h100] = 8'h80;
        mem[10'h101] = 8'h7F;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_wgt_out", int'(wgt_out), 0);
        chk("rst_wgt_read", int'(wgt_read), 0);
        chk("rst_kern_loaded", int'(kern_loaded), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_job(10'h010, 1, 0, 1'b0);   // single kernel, taps -4..4
        run_job(10'h010, 3, 5, 1'b1);   // three kernels, stray start/release
        run_job(10'h3FC, 1, 1, 1'b0);   // address wrap
        run_job(10'h000, 0, 0, 1'b0);   // empty job
        run_job(10'h100, 1, 0, 1'b0);   // -128 / +127 taps

        // Mid-job reset in the sixth FETCH cycle.
        @(posedge clk);
        #1;
        c0 = cyc;
        base_addr = ADDR_W'(10'h040);
        num_kern  = KCNT_W'(8'd1);
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e = '{c0 + 1 + i, 10'h040 + i, 0}; q_addr.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            e = '{c0 + 3 + i, 1 << i, int'($signed(mem[10'h040 + i]))}; q_wgt.push_back(e);
        end
        busy_lo = c0 + 1; busy_hi = c0 + 7;
        goto(c0 + 1); start = 1'b0;
        goto(c0 + 6); rst = 1'b1;
        goto(c0 + 7); rst = 1'b0;
        chk("abort_wgt_out", int'(wgt_out), 0);
        chk("abort_mem_addr", int'(mem_addr), 0);
        chk("abort_busy", int'(busy), 0);
        goto(c0 + 14);
        check_drained("abort_drained");
        run_job(10'h040, 1, 2, 1'b0);   // replay after reset

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
